// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO lane geometry and lane-count type
package fifo_pkg;
    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_PACK       = 4;
    localparam int FIFO_LANE_CNT_W = $clog2(FIFO_PACK + 1);

    typedef logic [FIFO_LANE_CNT_W-1:0] lane_cnt_t;
endpackage

// File: rtl/fifo_out_reg.sv
// rtl/fifo_out_reg.sv - packed output word register with valid/ready handshake
module fifo_out_reg #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [DATA_WIDTH*PACK-1:0] load_data,
    input  logic [PACK-1:0]            load_keep,
    input  logic                       m_ready,
    output logic                       m_valid,
    output logic [DATA_WIDTH*PACK-1:0] m_data,
    output logic [PACK-1:0]            m_keep,
    output logic                       out_free
);
    assign out_free = !m_valid || m_ready;

    // The top only asserts load when out_free, so a pending word is never overwritten.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_keep  <= load_keep;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fifo_pack_drain.sv
// rtl/fifo_pack_drain.sv - packs FIFO lanes into wide words, with flush of partial words
module fifo_pack_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int PACK       = FIFO_PACK
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_empty,
    output logic                         fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]        fifo_dout,
    input  logic                         flush,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH*PACK-1:0]   m_data,
    output logic [PACK-1:0]              m_keep,
    output logic [$clog2(PACK+1)-1:0]    fill_level
);
    localparam int CW      = $clog2(PACK + 1);
    localparam int PACK_M1 = PACK - 1;
    localparam logic [CW:0]   PACK_W = PACK[CW:0];
    localparam logic [CW-1:0] LAST   = PACK_M1[CW-1:0];
    localparam logic [CW-1:0] FULL   = PACK[CW-1:0];

    logic                       pend;
    logic                       hold;
    logic                       flush_pend;
    logic [CW-1:0]              fill;
    logic [CW:0]                committed;
    logic [DATA_WIDTH-1:0]      lanes [PACK];
    logic                       out_free;
    logic                       last_cap;
    logic                       full_load;
    logic                       hold_load;
    logic                       flush_accept;
    logic                       flush_fire;
    logic                       load;
    logic [DATA_WIDTH*PACK-1:0] full_word;
    logic [DATA_WIDTH*PACK-1:0] part_word;
    logic [PACK-1:0]            part_keep;
    logic [DATA_WIDTH*PACK-1:0] load_data;
    logic [PACK-1:0]            load_keep;

    assign committed = {1'b0, fill} + {{CW{1'b0}}, pend};
    assign last_cap  = pend && (fill == LAST);
    assign full_load = last_cap && out_free;
    assign hold_load = hold && out_free;

    // While held, fill sits at PACK so committed blocks further reads on its own.
    assign fifo_rd_en = rst && !fifo_empty && !flush_pend &&
                        ((committed < PACK_W) || (last_cap && out_free));

    // A flush landing on a word that is completing anyway is dropped.
    assign flush_accept = flush && !flush_pend && (committed != '0) && !last_cap && !hold;
    assign flush_fire   = flush_pend && !pend && !hold && out_free;
    assign load         = full_load || hold_load || (flush_fire && (fill != '0));

    always_comb begin
        full_word = '0;
        part_word = '0;
        part_keep = '0;
        for (int i = 0; i < PACK; i++) begin
            full_word[i*DATA_WIDTH +: DATA_WIDTH] = (i == PACK - 1 && pend) ? fifo_dout : lanes[i];
            if (i < int'(fill)) begin
                part_word[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
                part_keep[i]                          = 1'b1;
            end
        end
    end

    assign load_data = flush_fire ? part_word : full_word;
    assign load_keep = flush_fire ? part_keep : {PACK{1'b1}};

    always_ff @(posedge clk) begin
        for (int i = 0; i < PACK; i++) begin
            if (pend && fill == CW'(i)) begin
                lanes[i] <= fifo_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend       <= 1'b0;
            fill       <= '0;
            hold       <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            pend <= fifo_rd_en;
            if (pend) begin
                if (fill == LAST) begin
                    if (out_free) begin
                        fill <= '0;
                    end else begin
                        hold <= 1'b1;
                        fill <= FULL;
                    end
                end else begin
                    fill <= fill + CW'(1);
                end
            end
            if (hold_load) begin
                hold <= 1'b0;
                fill <= '0;
            end
            if (flush_fire) begin
                flush_pend <= 1'b0;
                fill       <= '0;
            end else if (flush_accept) begin
                flush_pend <= 1'b1;
            end
        end
    end

    assign fill_level = fill;

    fifo_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK       (PACK)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .out_free  (out_free)
    );
endmodule

// File: tb/tb_fifo_pack_drain.sv
// tb/tb_fifo_pack_drain.sv - directed and random bench for fifo_pack_drain with byte scoreboard
module tb_fifo_pack_drain;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [7:0]  fifo_dout = 8'h00;
    logic        flush;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    lane_cnt_t   fill_level;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    int beat_count = 0;

    logic [7:0]  fq[$];
    logic [7:0]  exp_q[$];
    logic [35:0] beat_log[$];
    logic        rd_acc = 1'b0;
    logic        rand_mode = 1'b0;
    logic        ready_dir = 1'b0;
    logic        gap;

    fifo_pack_drain #(.DATA_WIDTH(8), .PACK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Upstream FIFO model plus output monitor: drive at negedge+1, sample at negedge+2.
    always @(negedge clk) begin
        #1;
        if (rd_acc) begin
            if (fq.size() > 0) fifo_dout = fq.pop_front();
            rd_acc = 1'b0;
        end
        gap        = rand_mode && ($urandom_range(0, 3) == 0);
        fifo_empty = (fq.size() == 0) || gap;
        m_ready    = rand_mode ? 1'($urandom_range(0, 1)) : ready_dir;
        #1;
        if (!rst) begin
            rd_acc = 1'b0;
        end else begin
            chk("rd_while_empty", {63'b0, fifo_rd_en && fifo_empty}, 64'd0);
            if (fifo_rd_en) begin
                rd_acc = 1'b1;
                rd_count++;
            end
            if (m_valid && m_ready) begin
                beat_log.push_back({m_keep, m_data});
                beat_count++;
                for (int i = 0; i < 4; i++) begin
                    if (m_keep[i]) begin
                        if (exp_q.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
                        else chk("sb_lane", {56'b0, m_data[i*8 +: 8]}, {56'b0, exp_q.pop_front()});
                    end else begin
                        chk("sb_zero_lane", {56'b0, m_data[i*8 +: 8]}, 64'd0);
                    end
                end
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int k = 0;
        while (beat_count < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        #3;
        chk(tag, {63'b0, beat_count >= n}, 64'd1);
    endtask

    task automatic wait_fill(input int v, input int budget, input string tag);
        int k = 0;
        while (int'(fill_level) != v && k < budget) begin
            @(negedge clk);
            #3;
            k++;
        end
        chk(tag, {61'b0, fill_level}, v[63:0]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int r0;
        logic [31:0] held;

        rst = 1'b0;
        flush = 1'b0;
        ready_dir = 1'b1;
        for (int i = 1; i <= 4; i++) push_byte(8'(i * 8'h11));
        repeat (3) @(negedge clk);
        #3;
        chk("reset_m_valid", {63'b0, m_valid}, 64'd0);
        chk("reset_m_data", {32'b0, m_data}, 64'd0);
        chk("reset_m_keep", {60'b0, m_keep}, 64'd0);
        chk("reset_fill", {61'b0, fill_level}, 64'd0);
        chk("reset_rd_en", {63'b0, fifo_rd_en}, 64'd0);

        // Full word with the consumer always ready
        @(negedge clk);
        rst = 1'b1;
        wait_beats(1, 20, "t1_timeout");
        chk("t1_data", {32'b0, beat_log[0][31:0]}, 64'h44332211);
        chk("t1_keep", {60'b0, beat_log[0][35:32]}, 64'hF);
        chk("t1_rd_count", rd_count, 64'd4);

        // Backpressure: second word parks in hold, reads stop
        @(negedge clk);
        ready_dir = 1'b0;
        b0 = beat_count;
        r0 = rd_count;
        for (int i = 1; i <= 12; i++) push_byte(8'(i));
        repeat (14) @(negedge clk);
        #3;
        chk("t2_m_valid", {63'b0, m_valid}, 64'd1);
        chk("t2_data", {32'b0, m_data}, 64'h04030201);
        chk("t2_keep", {60'b0, m_keep}, 64'hF);
        chk("t2_hold_fill", {61'b0, fill_level}, 64'd4);
        chk("t2_reads", rd_count - r0, 64'd8);
        chk("t2_rd_stopped", {63'b0, fifo_rd_en}, 64'd0);
        held = m_data;
        repeat (3) @(negedge clk);
        #3;
        chk("t2_stable", {32'b0, m_data}, {32'b0, held});
        @(negedge clk);
        ready_dir = 1'b1;
        wait_beats(b0 + 3, 40, "t2_timeout");
        chk("t2_w0", {28'b0, beat_log[b0]}, 64'hF04030201);
        chk("t2_w1", {28'b0, beat_log[b0 + 1]}, 64'hF08070605);
        chk("t2_w2", {28'b0, beat_log[b0 + 2]}, 64'hF0C0B0A09);

        // Flush of a two-lane partial word
        @(negedge clk);
        b0 = beat_count;
        push_byte(8'hAA);
        push_byte(8'hBB);
        wait_fill(2, 20, "t3_fill2");
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_beats(b0 + 1, 20, "t3_timeout");
        chk("t3_word", {28'b0, beat_log[b0]}, 64'h30000BBAA);
        chk("t3_fill0", {61'b0, fill_level}, 64'd0);

        // Flush with nothing held is ignored
        @(negedge clk);
        b0 = beat_count;
        r0 = rd_count;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        chk("t4_no_beat", beat_count - b0, 64'd0);
        chk("t4_no_read", rd_count - r0, 64'd0);
        chk("t4_m_valid", {63'b0, m_valid}, 64'd0);

        // Reset mid-word drops the partial lanes
        @(negedge clk);
        push_byte(8'h51);
        push_byte(8'h52);
        wait_fill(2, 20, "t5_fill2");
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t5_m_valid", {63'b0, m_valid}, 64'd0);
        chk("t5_m_data", {32'b0, m_data}, 64'd0);
        chk("t5_m_keep", {60'b0, m_keep}, 64'd0);
        chk("t5_fill", {61'b0, fill_level}, 64'd0);
        chk("t5_rd_en", {63'b0, fifo_rd_en}, 64'd0);
        fq.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        b0 = beat_count;
        for (int i = 1; i <= 4; i++) push_byte(8'(8'h60 + i));
        wait_beats(b0 + 1, 20, "t5_timeout");
        chk("t5_word", {28'b0, beat_log[b0]}, 64'hF64636261);

        // Random backpressure and FIFO gaps over 64 bytes
        @(negedge clk);
        for (int i = 0; i < 64; i++) push_byte(8'($urandom_range(0, 255)));
        rand_mode = 1'b1;
        begin
            int k = 0;
            while ((exp_q.size() != 0 || fq.size() != 0) && k < 3000) begin
                @(negedge clk);
                k++;
            end
        end
        rand_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_drained", exp_q.size(), 64'd0);
        chk("t6_fifo_empty", fq.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
